mips_multicycle_ctrl: RTL

- Multi-cycle control FSM for the MIPS datapath; one instruction in flight.
- Consumes the opcode/funct fields produced by the instruction field splitter, plus the ALU zero flag and a memory handshake.
- Drives all datapath enables and selects for fetch, decode, execute, memory and write-back.
- Adds a memory-timeout watchdog, a sticky fault state and a retired-instruction counter.

---
 rtl/mips_ctrl_pkg.sv | 114 +++++++++++
 rtl/mips_alu_dec.sv | 46 ++++
 rtl/mips_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control path:
// FSM states, opcode/funct fields, ALU operations and datapath mux selects.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_WB_R,
      S_EXEC_I,
      S_WB_I,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_BRANCH,
      S_JUMP,
      S_JR,
      S_FAULT
   } state_t;

   localparam logic [5:0] OPC_R     = 6'h00;
   localparam logic [5:0] OPC_J     = 6'h02;
   localparam logic [5:0] OPC_JAL   = 6'h03;
   localparam logic [5:0] OPC_BEQ   = 6'h04;
   localparam logic [5:0] OPC_BNE   = 6'h05;
   localparam logic [5:0] OPC_ADDI  = 6'h08;
   localparam logic [5:0] OPC_ADDIU = 6'h09;
   localparam logic [5:0] OPC_SLTI  = 6'h0A;
   localparam logic [5:0] OPC_SLTIU = 6'h0B;
   localparam logic [5:0] OPC_ANDI  = 6'h0C;
   localparam logic [5:0] OPC_ORI   = 6'h0D;
   localparam logic [5:0] OPC_XORI  = 6'h0E;
   localparam logic [5:0] OPC_LUI   = 6'h0F;
   localparam logic [5:0] OPC_LW    = 6'h23;
   localparam logic [5:0] OPC_SW    = 6'h2B;

   localparam logic [5:0] FUN_SLL  = 6'h00;
   localparam logic [5:0] FUN_SRL  = 6'h02;
   localparam logic [5:0] FUN_SRA  = 6'h03;
   localparam logic [5:0] FUN_SLLV = 6'h04;
   localparam logic [5:0] FUN_SRLV = 6'h06;
   localparam logic [5:0] FUN_SRAV = 6'h07;
   localparam logic [5:0] FUN_JR   = 6'h08;
   localparam logic [5:0] FUN_ADD  = 6'h20;
   localparam logic [5:0] FUN_ADDU = 6'h21;
   localparam logic [5:0] FUN_SUB  = 6'h22;
   localparam logic [5:0] FUN_SUBU = 6'h23;
   localparam logic [5:0] FUN_AND  = 6'h24;
   localparam logic [5:0] FUN_OR   = 6'h25;
   localparam logic [5:0] FUN_XOR  = 6'h26;
   localparam logic [5:0] FUN_NOR  = 6'h27;
   localparam logic [5:0] FUN_SLT  = 6'h2A;
   localparam logic [5:0] FUN_SLTU = 6'h2B;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_LUI  = 4'd11
   } alu_op_t;

   localparam logic [1:0] PC_SRC_ALU    = 2'd0;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
   localparam logic [1:0] PC_SRC_RS     = 2'd3;

   localparam logic       SRC_A_PC = 1'b0;
   localparam logic       SRC_A_RS = 1'b1;

   localparam logic [1:0] SRC_B_RT     = 2'd0;
   localparam logic [1:0] SRC_B_FOUR   = 2'd1;
   localparam logic [1:0] SRC_B_IMM    = 2'd2;
   localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

   localparam logic [1:0] DST_RT  = 2'd0;
   localparam logic [1:0] DST_RD  = 2'd1;
   localparam logic [1:0] DST_R31 = 2'd2;

   localparam logic [1:0] WB_ALUOUT = 2'd0;
   localparam logic [1:0] WB_MDR    = 2'd1;
   localparam logic [1:0] WB_PC     = 2'd2;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       imm_sext;
      alu_op_t    alu_op;
      logic       reg_we;
      logic [1:0] reg_dst;
      logic [1:0] wb_src;
      logic       fault;
   } ctrl_t;

   // States that hold a memory request open and are therefore watched by the timeout.
   function automatic logic is_req_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// Combinational opcode/funct decoder: picks the ALU operation for the
// instruction in IR and flags whether the encoding is one we support.
module mips_alu_dec
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opc,
   input  logic [5:0] fun,
   output alu_op_t    alu_op,
   output logic       legal
);

   // Shift variants share one ALU op; the datapath picks shamt or rs as amount.
   always_comb begin
      alu_op = ALU_ADD;
      legal  = 1'b1;
      case (opc)
         OPC_R: begin
            case (fun)
               FUN_SLL, FUN_SLLV:  alu_op = ALU_SLL;
               FUN_SRL, FUN_SRLV:  alu_op = ALU_SRL;
               FUN_SRA, FUN_SRAV:  alu_op = ALU_SRA;
               FUN_JR:             alu_op = ALU_ADD;
               FUN_ADD, FUN_ADDU:  alu_op = ALU_ADD;
               FUN_SUB, FUN_SUBU:  alu_op = ALU_SUB;
               FUN_AND:            alu_op = ALU_AND;
               FUN_OR:             alu_op = ALU_OR;
               FUN_XOR:            alu_op = ALU_XOR;
               FUN_NOR:            alu_op = ALU_NOR;
               FUN_SLT:            alu_op = ALU_SLT;
               FUN_SLTU:           alu_op = ALU_SLTU;
               default:            legal  = 1'b0;
            endcase
         end
         OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW, OPC_J, OPC_JAL: alu_op = ALU_ADD;
         OPC_BEQ, OPC_BNE: alu_op = ALU_SUB;
         OPC_SLTI:         alu_op = ALU_SLT;
         OPC_SLTIU:        alu_op = ALU_SLTU;
         OPC_ANDI:         alu_op = ALU_AND;
         OPC_ORI:          alu_op = ALU_OR;
         OPC_XORI:         alu_op = ALU_XOR;
         OPC_LUI:          alu_op = ALU_LUI;
         default:          legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-timeout watchdog, absorbing
// fault state and a retired-instruction counter.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
)(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [5:0]       i_opc,
   input  logic [5:0]       i_fun,
   input  logic             i_alu_zero,
   input  logic             i_mem_ack,
   output logic             o_mem_req,
   output logic             o_mem_we,
   output logic             o_iord,
   output logic             o_ir_we,
   output logic             o_pc_we,
   output logic [1:0]       o_pc_src,
   output logic             o_alu_src_a,
   output logic [1:0]       o_alu_src_b,
   output logic             o_imm_sext,
   output logic [3:0]       o_alu_op,
   output logic             o_reg_we,
   output logic [1:0]       o_reg_dst,
   output logic [1:0]       o_wb_src,
   output logic             o_fault,
   output logic [CNT_W-1:0] o_retired
);

   localparam int             WD_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);

   state_t            state_q;
   state_t            state_d;
   logic [WD_W-1:0]   wd_cnt;
   logic              wd_expired;
   logic              retire;
   ctrl_t             ctrl;
   alu_op_t           dec_alu_op;
   logic              dec_legal;
   logic [CNT_W-1:0]  retired_q;

   mips_alu_dec u_alu_dec (
      .opc    (i_opc),
      .fun    (i_fun),
      .alu_op (dec_alu_op),
      .legal  (dec_legal)
   );

   // The last allowed waiting cycle without ack trips the watchdog; an ack there still wins.
   assign wd_expired = !i_mem_ack && (wd_cnt == WD_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wd_cnt <= '0;
      end else if (is_req_state(state_q) && !i_mem_ack && !wd_expired) begin
         wd_cnt <= wd_cnt + 1'b1;
      end else begin
         wd_cnt <= '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         retired_q <= '0;
      end else if (retire) begin
         retired_q <= retired_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH: begin
            if (i_mem_ack)       state_d = S_DECODE;
            else if (wd_expired) state_d = S_FAULT;
         end
         S_DECODE: begin
            if (!dec_legal) begin
               state_d = S_FAULT;
            end else begin
               case (i_opc)
                  OPC_R:       state_d = (i_fun == FUN_JR) ? S_JR : S_EXEC_R;
                  OPC_ADDI, OPC_ADDIU, OPC_ANDI, OPC_ORI, OPC_XORI,
                  OPC_SLTI, OPC_SLTIU, OPC_LUI: state_d = S_EXEC_I;
                  OPC_LW, OPC_SW:   state_d = S_MEM_ADDR;
                  OPC_BEQ, OPC_BNE: state_d = S_BRANCH;
                  OPC_J, OPC_JAL:   state_d = S_JUMP;
                  default:          state_d = S_FAULT;
               endcase
            end
         end
         S_EXEC_R:   state_d = S_WB_R;
         S_EXEC_I:   state_d = S_WB_I;
         S_MEM_ADDR: begin
            if (i_opc == OPC_LW)      state_d = S_MEM_RD;
            else if (i_opc == OPC_SW) state_d = S_MEM_WR;
            else                      state_d = S_FAULT;
         end
         S_MEM_RD: begin
            if (i_mem_ack)       state_d = S_MEM_WB;
            else if (wd_expired) state_d = S_FAULT;
         end
         S_MEM_WR: begin
            if (i_mem_ack)       state_d = S_FETCH;
            else if (wd_expired) state_d = S_FAULT;
         end
         S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
         S_FAULT:    state_d = S_FAULT;
         default:    state_d = S_FAULT;
      endcase
   end

   // Outputs are forced idle while reset is held so nothing is written in the reset cycle.
   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = ALU_ADD;
      retire      = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.iord      = 1'b0;
            ctrl.alu_src_a = SRC_A_PC;
            ctrl.alu_src_b = SRC_B_FOUR;
            ctrl.ir_we     = i_mem_ack;
            ctrl.pc_we     = i_mem_ack;
            ctrl.pc_src    = PC_SRC_ALU;
         end
         S_DECODE: begin
            ctrl.alu_src_a = SRC_A_PC;
            ctrl.alu_src_b = SRC_B_IMM_SH;
            ctrl.imm_sext  = 1'b1;
         end
         S_EXEC_R: begin
            ctrl.alu_src_a = SRC_A_RS;
            ctrl.alu_src_b = SRC_B_RT;
            ctrl.alu_op    = dec_alu_op;
         end
         S_WB_R: begin
            ctrl.reg_we  = 1'b1;
            ctrl.reg_dst = DST_RD;
            ctrl.wb_src  = WB_ALUOUT;
            retire       = 1'b1;
         end
         S_EXEC_I: begin
            ctrl.alu_src_a = SRC_A_RS;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.alu_op    = dec_alu_op;
            ctrl.imm_sext  = !((i_opc == OPC_ANDI) || (i_opc == OPC_ORI) || (i_opc == OPC_XORI));
         end
         S_WB_I: begin
            ctrl.reg_we  = 1'b1;
            ctrl.reg_dst = DST_RT;
            ctrl.wb_src  = WB_ALUOUT;
            retire       = 1'b1;
         end
         S_MEM_ADDR: begin
            ctrl.alu_src_a = SRC_A_RS;
            ctrl.alu_src_b = SRC_B_IMM;
            ctrl.imm_sext  = 1'b1;
         end
         S_MEM_RD: begin
            ctrl.mem_req = 1'b1;
            ctrl.iord    = 1'b1;
            ctrl.mem_we  = 1'b0;
         end
         S_MEM_WB: begin
            ctrl.reg_we  = 1'b1;
            ctrl.reg_dst = DST_RT;
            ctrl.wb_src  = WB_MDR;
            retire       = 1'b1;
         end
         S_MEM_WR: begin
            ctrl.mem_req = 1'b1;
            ctrl.iord    = 1'b1;
            ctrl.mem_we  = 1'b1;
            retire       = i_mem_ack;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = SRC_A_RS;
            ctrl.alu_src_b = SRC_B_RT;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_src    = PC_SRC_ALUOUT;
            ctrl.pc_we     = (i_opc == OPC_BNE) ? !i_alu_zero : i_alu_zero;
            retire         = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = PC_SRC_JUMP;
            if (i_opc == OPC_JAL) begin
               ctrl.reg_we  = 1'b1;
               ctrl.reg_dst = DST_R31;
               ctrl.wb_src  = WB_PC;
            end
            retire = 1'b1;
         end
         S_JR: begin
            ctrl.pc_we  = 1'b1;
            ctrl.pc_src = PC_SRC_RS;
            retire      = 1'b1;
         end
         S_FAULT: begin
            ctrl.fault = 1'b1;
         end
         default: begin
            ctrl.fault = 1'b1;
         end
      endcase
      if (!i_rst_n) begin
         ctrl        = '0;
         ctrl.alu_op = ALU_ADD;
         retire      = 1'b0;
      end
   end

   assign o_mem_req   = ctrl.mem_req;
   assign o_mem_we    = ctrl.mem_we;
   assign o_iord      = ctrl.iord;
   assign o_ir_we     = ctrl.ir_we;
   assign o_pc_we     = ctrl.pc_we;
   assign o_pc_src    = ctrl.pc_src;
   assign o_alu_src_a = ctrl.alu_src_a;
   assign o_alu_src_b = ctrl.alu_src_b;
   assign o_imm_sext  = ctrl.imm_sext;
   assign o_alu_op    = ctrl.alu_op;
   assign o_reg_we    = ctrl.reg_we;
   assign o_reg_dst   = ctrl.reg_dst;
   assign o_wb_src    = ctrl.wb_src;
   assign o_fault     = ctrl.fault;
   assign o_retired   = retired_q;

endmodule
